// File: rtl/aer_frame_sender_pkg.sv
// ============================================================================
// aer_pkg : shared AER constants, address layout and state encodings
// Revision: 1.0
// ============================================================================
`default_nettype none

package aer_pkg;

   // Address layout: bit 11 reserved, bit 10 marker flag, bits [9:0] neuron
   localparam int                    AER_ADDR_W      = 12;
   localparam int                    NEURON_W        = 10;
   localparam logic [AER_ADDR_W-1:0] AER_MARKER_ADDR = 12'h4FF;

   typedef enum logic [1:0] {
      SND_LOAD = 2'd0,
      SND_SCAN = 2'd1,
      SND_SEND = 2'd2
   } sender_state_e;

   typedef enum logic [2:0] {
      HS_IDLE   = 3'd0,
      HS_SETUP  = 3'd1,
      HS_REQ_HI = 3'd2,
      HS_ACK_LO = 3'd3,
      HS_GAP    = 3'd4
   } hs_state_e;

   function automatic logic [AER_ADDR_W-1:0] pixel_addr(input logic [NEURON_W-1:0] pix);
      return {2'b00, pix};
   endfunction

endpackage

`default_nettype wire

// File: rtl/aer_frame_sender_if.sv
// ============================================================================
// aer_frame_sender_if : byte-load, scheduler and AER link signals of the sender
// Revision: 1.0
// ============================================================================
`default_nettype none

interface aer_frame_sender_if #(
   parameter int T = 8
);
   import aer_pkg::*;

   localparam int STEP_W = (T > 1) ? $clog2(T) : 1;

   logic                  LOAD_VALID;
   logic [7:0]            LOAD_DATA;
   logic                  LOAD_READY;
   logic                  SCHED_FULL;
   logic [AER_ADDR_W-1:0] AERIN_ADDR;
   logic                  AERIN_REQ;
   logic                  AERIN_ACK;
   logic [STEP_W-1:0]     STEP;
   logic [9:0]            SPK_CNT;
   logic                  SAMPLE_DONE;

   modport master (
      input  LOAD_VALID, LOAD_DATA, SCHED_FULL, AERIN_ACK,
      output LOAD_READY, AERIN_ADDR, AERIN_REQ, STEP, SPK_CNT, SAMPLE_DONE
   );

   modport slave (
      output LOAD_VALID, LOAD_DATA, SCHED_FULL, AERIN_ACK,
      input  LOAD_READY, AERIN_ADDR, AERIN_REQ, STEP, SPK_CNT, SAMPLE_DONE
   );

endinterface

`default_nettype wire

// File: rtl/aer_frame_sender_4ph_master.sv
// ============================================================================
// aer_4ph_master : one 4-phase REQ/ACK transfer per start, then an idle gap
// Revision: 1.0
// ============================================================================
`default_nettype none

module aer_4ph_master
   import aer_pkg::*;
#(
   parameter int GAP_CYCLES = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  start_i,
   input  logic [AER_ADDR_W-1:0] addr_i,
   input  logic                  sched_full_i,
   input  logic                  ack_i,
   output logic [AER_ADDR_W-1:0] addr_o,
   output logic                  req_o,
   output logic                  done_o
);

   localparam int               GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   hs_state_e             state_q;
   logic [GAP_W-1:0]      gap_q;
   logic [AER_ADDR_W-1:0] addr_q;
   logic                  req_q;

   assign addr_o = addr_q;
   assign req_o  = req_q;

   // done is combinational so a queued start can enter SETUP on the same edge
   always_comb begin
      done_o = 1'b0;
      case (state_q)
         HS_ACK_LO: done_o = !ack_i && (GAP_CYCLES == 0);
         HS_GAP:    done_o = (gap_q == GAP_LAST);
         default:   done_o = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= HS_IDLE;
         gap_q   <= '0;
         addr_q  <= '0;
         req_q   <= 1'b0;
      end else begin
         case (state_q)
            HS_IDLE: begin
               if (start_i) begin
                  addr_q  <= addr_i;
                  state_q <= HS_SETUP;
               end
            end
            HS_SETUP: begin
               // a stale ACK from the previous transfer must clear before REQ rises
               if (!ack_i && !sched_full_i) begin
                  req_q   <= 1'b1;
                  state_q <= HS_REQ_HI;
               end
            end
            HS_REQ_HI: begin
               if (ack_i) begin
                  req_q   <= 1'b0;
                  state_q <= HS_ACK_LO;
               end
            end
            HS_ACK_LO: begin
               if (!ack_i) begin
                  gap_q <= '0;
                  if (GAP_CYCLES > 0) begin
                     state_q <= HS_GAP;
                  end else if (start_i) begin
                     addr_q  <= addr_i;
                     state_q <= HS_SETUP;
                  end else begin
                     state_q <= HS_IDLE;
                  end
               end
            end
            HS_GAP: begin
               if (gap_q == GAP_LAST) begin
                  if (start_i) begin
                     addr_q  <= addr_i;
                     state_q <= HS_SETUP;
                  end else begin
                     state_q <= HS_IDLE;
                  end
               end else begin
                  gap_q <= gap_q + GAP_W'(1);
               end
            end
            default: state_q <= HS_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/aer_frame_sender.sv
// ============================================================================
// aer_frame_sender : loads a spike frame byte-wise, emits one AER event per
// set pixel followed by a time-step marker, and tracks steps per sample.
// Revision: 1.0
// ============================================================================
`default_nettype none

module aer_frame_sender
   import aer_pkg::*;
#(
   parameter int                    WIDTH       = 784,
   parameter int                    T           = 8,
   parameter int                    GAP_CYCLES  = 2,
   parameter logic [AER_ADDR_W-1:0] MARKER_ADDR = AER_MARKER_ADDR
) (
   input  logic               CLK,
   input  logic               RST_N,
   aer_frame_sender_if.master bus
);

   localparam int                NB        = (WIDTH + 7) / 8;
   localparam int                BP_W      = (NB > 1) ? $clog2(NB) : 1;
   localparam int                STEP_W    = (T > 1) ? $clog2(T) : 1;
   localparam logic [BP_W-1:0]   LAST_BYTE = BP_W'(NB - 1);
   localparam logic [9:0]        LAST_PIX  = 10'(WIDTH - 1);
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(T - 1);

   sender_state_e         state_q;
   logic [7:0]            frame_q [NB];
   logic [BP_W-1:0]       byte_ptr_q;
   logic [9:0]            scan_ptr_q;
   logic [9:0]            pix_q;
   logic                  marker_q;
   logic                  ready_q;
   logic [STEP_W-1:0]     step_q;
   logic [9:0]            spk_cnt_q;
   logic                  sample_done_q;

   logic                  scan_bit;
   logic                  hs_start;
   logic [AER_ADDR_W-1:0] hs_start_addr;
   logic                  hs_done;

   // Bytes are stored whole; MSB of each byte is its lowest pixel
   assign scan_bit = frame_q[BP_W'(scan_ptr_q >> 3)][~scan_ptr_q[2:0]];

   always_comb begin
      hs_start      = 1'b0;
      hs_start_addr = MARKER_ADDR;
      case (state_q)
         SND_SCAN: begin
            if (scan_bit) begin
               hs_start      = 1'b1;
               hs_start_addr = pixel_addr(scan_ptr_q);
            end else if (scan_ptr_q == LAST_PIX) begin
               hs_start = 1'b1;
            end
         end
         SND_SEND: begin
            // the last pixel was an event: chain the marker without rescanning
            if (hs_done && !marker_q && (pix_q == LAST_PIX)) begin
               hs_start = 1'b1;
            end
         end
         default: hs_start = 1'b0;
      endcase
   end

   aer_4ph_master #(
      .GAP_CYCLES (GAP_CYCLES)
   ) u_master (
      .clk_i        (CLK),
      .rst_n_i      (RST_N),
      .start_i      (hs_start),
      .addr_i       (hs_start_addr),
      .sched_full_i (bus.SCHED_FULL),
      .ack_i        (bus.AERIN_ACK),
      .addr_o       (bus.AERIN_ADDR),
      .req_o        (bus.AERIN_REQ),
      .done_o       (hs_done)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q       <= SND_LOAD;
         byte_ptr_q    <= '0;
         scan_ptr_q    <= '0;
         pix_q         <= '0;
         marker_q      <= 1'b0;
         ready_q       <= 1'b0;
         step_q        <= '0;
         spk_cnt_q     <= '0;
         sample_done_q <= 1'b0;
         for (int i = 0; i < NB; i++) begin
            frame_q[i] <= '0;
         end
      end else begin
         sample_done_q <= 1'b0;
         case (state_q)
            SND_LOAD: begin
               ready_q <= 1'b1;
               if (bus.LOAD_VALID && ready_q) begin
                  frame_q[byte_ptr_q] <= bus.LOAD_DATA;
                  if (byte_ptr_q == LAST_BYTE) begin
                     ready_q    <= 1'b0;
                     byte_ptr_q <= '0;
                     scan_ptr_q <= '0;
                     state_q    <= SND_SCAN;
                  end else begin
                     byte_ptr_q <= byte_ptr_q + BP_W'(1);
                  end
               end
            end
            SND_SCAN: begin
               if (hs_start) begin
                  pix_q    <= scan_ptr_q;
                  marker_q <= !scan_bit;
                  state_q  <= SND_SEND;
               end else begin
                  scan_ptr_q <= scan_ptr_q + 10'd1;
               end
            end
            SND_SEND: begin
               if (hs_done) begin
                  if (marker_q) begin
                     marker_q  <= 1'b0;
                     spk_cnt_q <= '0;
                     ready_q   <= 1'b1;
                     state_q   <= SND_LOAD;
                     if (step_q == LAST_STEP) begin
                        step_q        <= '0;
                        sample_done_q <= 1'b1;
                     end else begin
                        step_q <= step_q + STEP_W'(1);
                     end
                  end else begin
                     if (spk_cnt_q != 10'h3FF) begin
                        spk_cnt_q <= spk_cnt_q + 10'd1;
                     end
                     if (pix_q == LAST_PIX) begin
                        marker_q <= 1'b1;
                     end else begin
                        scan_ptr_q <= pix_q + 10'd1;
                        state_q    <= SND_SCAN;
                     end
                  end
               end
            end
            default: state_q <= SND_LOAD;
         endcase
      end
   end

   assign bus.LOAD_READY  = ready_q;
   assign bus.STEP        = step_q;
   assign bus.SPK_CNT     = spk_cnt_q;
   assign bus.SAMPLE_DONE = sample_done_q;

endmodule

`default_nettype wire

// File: tb/tb_aer_frame_sender.sv
// ============================================================================
// tb_aer_frame_sender : directed frame vectors plus handshake corner sequences
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_aer_frame_sender;
   import aer_pkg::*;

   localparam int WIDTH = 784;
   localparam int T     = 2;
   localparam int GAP   = 2;
   localparam int NB    = (WIDTH + 7) / 8;
   localparam int BOUND = 30000;

   logic CLK   = 1'b0;
   logic RST_N = 1'b1;
   always #5 CLK = ~CLK;

   aer_frame_sender_if #(.T(T)) aer_if ();

   aer_frame_sender #(
      .WIDTH       (WIDTH),
      .T           (T),
      .GAP_CYCLES  (GAP),
      .MARKER_ADDR (12'h4FF)
   ) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (aer_if)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [11:0] ev_addr[$];
   logic [9:0]  ev_spk[$];
   int ack_dly      = 0;
   int rel_dly      = 0;
   int stab_err     = 0;
   int ack_fall_cyc = 0;
   int ready_rise_cyc = 0;
   int sd_cnt       = 0;
   int sd_long      = 0;
   int exp_step     = 0;

   typedef struct {
      string name;
      int    p0;
      int    p1;
      int    p2;
      bit    all;
      int    exp_spk;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   initial forever begin
      @(posedge CLK);
      cyc++;
   end

   // Core-side responder with programmable ACK assertion/release delays
   initial begin
      int          rstate;
      int          rcnt;
      logic [11:0] raddr;
      rstate = 0;
      rcnt   = 0;
      raddr  = '0;
      aer_if.AERIN_ACK = 1'b0;
      forever begin
         @(negedge CLK);
         if (!RST_N) begin
            rstate = 0;
            aer_if.AERIN_ACK = 1'b0;
         end else begin
            case (rstate)
               0: if (aer_if.AERIN_REQ) begin
                  raddr = aer_if.AERIN_ADDR;
                  ev_addr.push_back(raddr);
                  ev_spk.push_back(aer_if.SPK_CNT);
                  rcnt = 0;
                  if (ack_dly == 0) begin
                     aer_if.AERIN_ACK = 1'b1;
                     rstate = 2;
                  end else begin
                     rstate = 1;
                  end
               end
               1: begin
                  rcnt++;
                  if (!aer_if.AERIN_REQ || aer_if.AERIN_ADDR !== raddr) stab_err++;
                  if (rcnt >= ack_dly) begin
                     aer_if.AERIN_ACK = 1'b1;
                     rstate = 2;
                  end
               end
               2: begin
                  if (aer_if.AERIN_ADDR !== raddr) stab_err++;
                  if (!aer_if.AERIN_REQ) begin
                     rcnt = 0;
                     if (rel_dly == 0) begin
                        aer_if.AERIN_ACK = 1'b0;
                        ack_fall_cyc = cyc;
                        rstate = 0;
                     end else begin
                        rstate = 3;
                     end
                  end
               end
               3: begin
                  rcnt++;
                  if (aer_if.AERIN_REQ || aer_if.AERIN_ADDR !== raddr) stab_err++;
                  if (rcnt >= rel_dly) begin
                     aer_if.AERIN_ACK = 1'b0;
                     ack_fall_cyc = cyc;
                     rstate = 0;
                  end
               end
               default: rstate = 0;
            endcase
         end
      end
   end

   initial begin
      logic sd_prev;
      logic rdy_prev;
      sd_prev  = 1'b0;
      rdy_prev = 1'b0;
      forever begin
         @(negedge CLK);
         if (aer_if.SAMPLE_DONE === 1'b1) begin
            sd_cnt++;
            if (sd_prev) sd_long++;
         end
         if (aer_if.LOAD_READY === 1'b1 && !rdy_prev) ready_rise_cyc = cyc;
         sd_prev  = (aer_if.SAMPLE_DONE === 1'b1);
         rdy_prev = (aer_if.LOAD_READY === 1'b1);
      end
   end

   task automatic load_frame(input logic [WIDTH-1:0] fr);
      int n;
      for (int b = 0; b < NB; b++) begin
         logic [7:0] d;
         d = '0;
         for (int k = 0; k < 8; k++) begin
            if (8 * b + k < WIDTH) d[7-k] = fr[8*b+k];
         end
         @(negedge CLK);
         aer_if.LOAD_VALID = 1'b1;
         aer_if.LOAD_DATA  = d;
         n = 0;
         while (!aer_if.LOAD_READY && n < 1000) begin
            @(negedge CLK);
            n++;
         end
         chk("load_ready_wait", aer_if.LOAD_READY, 1);
      end
      @(negedge CLK);
      aer_if.LOAD_VALID = 1'b0;
      chk("ready_drops_after_last_byte", aer_if.LOAD_READY, 0);
   endtask

   // Loads a frame, optionally holds SCHED_FULL over the first event, then
   // checks every event, the marker-time SPK_CNT, STEP and SAMPLE_DONE.
   task automatic run_frame(input logic [WIDTH-1:0] fr, input int exp_spk,
                            input string nm, input bit hold_full);
      logic [11:0] exp_ev[$];
      int   n;
      int   sd0;
      bit   req_seen;
      bit   exp_sd;
      for (int i = 0; i < WIDTH; i++) begin
         if (fr[i]) exp_ev.push_back({2'b00, 10'(i)});
      end
      exp_ev.push_back(12'h4FF);
      ev_addr.delete();
      ev_spk.delete();
      sd0 = sd_cnt;
      if (hold_full) aer_if.SCHED_FULL = 1'b1;
      load_frame(fr);
      if (hold_full) begin
         req_seen = 1'b0;
         for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if (aer_if.AERIN_REQ) req_seen = 1'b1;
         end
         chk({nm, "_req_blocked_by_full"}, req_seen, 0);
         aer_if.SCHED_FULL = 1'b0;
         @(negedge CLK);
         chk({nm, "_req_after_full"}, aer_if.AERIN_REQ, 1);
         chk({nm, "_addr_after_full"}, aer_if.AERIN_ADDR, exp_ev[0]);
      end
      n = 0;
      while ((ev_addr.size() < exp_ev.size() || !aer_if.LOAD_READY) && n < BOUND) begin
         @(negedge CLK);
         n++;
      end
      chk({nm, "_event_count"}, ev_addr.size(), exp_ev.size());
      for (int i = 0; i < exp_ev.size(); i++) begin
         if (i < ev_addr.size()) chk({nm, "_event_addr"}, ev_addr[i], exp_ev[i]);
      end
      if (ev_spk.size() == exp_ev.size())
         chk({nm, "_spk_cnt_at_marker"}, ev_spk[ev_spk.size()-1], exp_spk);
      @(negedge CLK);
      exp_sd   = (exp_step == T - 1);
      exp_step = (exp_step + 1) % T;
      chk({nm, "_step"}, aer_if.STEP, exp_step);
      chk({nm, "_sample_done_pulses"}, sd_cnt - sd0, exp_sd);
      chk({nm, "_spk_cnt_cleared"}, aer_if.SPK_CNT, 0);
   endtask

   initial begin
      logic [WIDTH-1:0] fr;
      int n;
      int stab0;

      aer_if.LOAD_VALID = 1'b0;
      aer_if.LOAD_DATA  = '0;
      aer_if.SCHED_FULL = 1'b0;

      vecs[0] = '{"three_pix",  0,  5, 783, 1'b0, 3};
      vecs[1] = '{"empty",     -1, -1,  -1, 1'b0, 0};
      vecs[2] = '{"last_only", 783, -1, -1, 1'b0, 1};
      vecs[3] = '{"adjacent",   1,  2,   3, 1'b0, 3};
      vecs[4] = '{"full",      -1, -1,  -1, 1'b1, 784};

      #1 RST_N = 1'b0;
      #2;
      chk("rst_addr",  aer_if.AERIN_ADDR, 0);
      chk("rst_req",   aer_if.AERIN_REQ, 0);
      chk("rst_ready", aer_if.LOAD_READY, 0);
      chk("rst_step",  aer_if.STEP, 0);
      chk("rst_spk",   aer_if.SPK_CNT, 0);
      chk("rst_sd",    aer_if.SAMPLE_DONE, 0);
      @(negedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);
      chk("ready_after_reset", aer_if.LOAD_READY, 1);

      ack_dly = 0;
      rel_dly = 0;
      for (int v = 0; v < 5; v++) begin
         fr = vecs[v].all ? '1 : '0;
         if (vecs[v].p0 >= 0) fr[vecs[v].p0] = 1'b1;
         if (vecs[v].p1 >= 0) fr[vecs[v].p1] = 1'b1;
         if (vecs[v].p2 >= 0) fr[vecs[v].p2] = 1'b1;
         run_frame(fr, vecs[v].exp_spk, vecs[v].name, 1'b0);
      end

      // Empty frame: LOAD_READY returns GAP+1 edges after the marker ACK falls
      run_frame('0, 0, "empty_gap", 1'b0);
      chk("ready_latency_after_marker", ready_rise_cyc - ack_fall_cyc, GAP + 1);

      // Slow responder: REQ/ADDR held, stale ACK respected, no duplicates
      ack_dly = 25;
      rel_dly = 40;
      stab0 = stab_err;
      fr = '0;
      fr[10] = 1'b1;
      fr[11] = 1'b1;
      fr[500] = 1'b1;
      run_frame(fr, 3, "slow_ack", 1'b0);
      chk("slow_ack_hold_stable", stab_err - stab0, 0);

      // Scheduler full while pixel 10 is pending
      ack_dly = 0;
      rel_dly = 0;
      fr = '0;
      fr[10] = 1'b1;
      run_frame(fr, 1, "sched_full", 1'b1);

      // Reset mid-handshake
      ack_dly = 60;
      fr = '0;
      fr[100] = 1'b1;
      fr[200] = 1'b1;
      ev_addr.delete();
      ev_spk.delete();
      load_frame(fr);
      n = 0;
      while (!aer_if.AERIN_REQ && n < 1000) begin
         @(negedge CLK);
         n++;
      end
      chk("req_before_reset", aer_if.AERIN_REQ, 1);
      @(negedge CLK);
      #2 RST_N = 1'b0;
      #1;
      chk("async_reset_req",   aer_if.AERIN_REQ, 0);
      chk("async_reset_step",  aer_if.STEP, 0);
      chk("async_reset_ready", aer_if.LOAD_READY, 0);
      @(negedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;
      exp_step = 0;
      @(negedge CLK);
      chk("ready_after_mid_reset", aer_if.LOAD_READY, 1);
      ack_dly = 0;
      fr = '0;
      fr[3] = 1'b1;
      run_frame(fr, 1, "after_reset", 1'b0);

      chk("sample_done_width", sd_long, 0);
      chk("handshake_stability", stab_err, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog_timeout actual=%0d required=finish", cyc);
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire

// File: doc/aer_frame_sender.md
Name: aer_frame_sender

Overview:
- Upstream stimulus stage for the FF-STDP ODIN core. Replaces bench-driven AER stimulus with synthesizable logic.
- Accepts one time step of binary spike pixels as a byte stream and stores it in a frame register.
- Scans the frame and emits one AER event per set pixel on a 4-phase REQ/ACK link. Then emits the time-step marker.
- Counts time steps per sample and flags sample completion.

Parameters:
- WIDTH, 784, pixels per time step; must be ≤1024.
- T, 8, time steps per sample.
- GAP_CYCLES, 2, idle cycles after each completed handshake before the next event (0 allowed).
- MARKER_ADDR, 12'h4FF, AER address of the end-of-time-step marker ({1'b0,1'b1,10'hFF}).

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  reset.
- LOAD_VALID  in  1  load byte valid.
- LOAD_DATA  in  8  spike byte, MSB = lowest pixel.
- LOAD_READY  out  1  frame register accepting bytes.
- SCHED_FULL  in  1  core scheduler full; blocks new REQ.
- AERIN_ADDR  out  12  AER event address to core.
- AERIN_REQ  out  1  AER request.
- AERIN_ACK  in  1  AER acknowledge from core (same clock domain).
- STEP  out  $clog2(T)  current time-step index.
- SPK_CNT  out  10  events sent in current frame, excluding marker.
- SAMPLE_DONE  out  1  one-cycle pulse after the last marker of a sample.

Behaviour:
- Reset is asynchronous and active-low: RST_N low clears all state immediately, with no clock edge required.
- Reset values: state=LOAD, byte pointer 0, frame 0, AERIN_ADDR 0, AERIN_REQ 0, LOAD_READY 0, STEP 0, SPK_CNT 0, SAMPLE_DONE 0.
- All outputs are registered. LOAD_READY rises on the first CLK edge after RST_N deasserts.
- Load rule: a byte is accepted when LOAD_VALID && LOAD_READY at the clock edge.
  - Byte b, bit 7-k maps to pixel 8b+k.
  - NB = ceil(WIDTH/8) bytes form one frame. Bits beyond WIDTH-1 are discarded.
  - When byte NB-1 is accepted, LOAD_READY drops on the next edge and the state goes to SCAN.
- States:
  - LOAD: collect bytes; SPK_CNT cleared on entry.
  - SCAN: examine 1 pixel/cycle, starting from pixel 0 or from the pixel after the last event.
    - Set bit → SETUP, latch pixel index.
    - After pixel WIDTH-1 with no further set bit → SETUP with the marker flag set.
  - SETUP: drive AERIN_ADDR = {2'b00, pix[9:0]} (or MARKER_ADDR), REQ=0. Advance to REQ_HI only when AERIN_ACK==0 && SCHED_FULL==0. ADDR is therefore stable ≥1 cycle before REQ rises.
  - REQ_HI: REQ=1. On ACK==1, REQ drops on the next edge → ACK_LO.
  - ACK_LO: wait for ACK==0. Then:
    - GAP if GAP_CYCLES>0, otherwise next state directly.
    - SPK_CNT increments for pixel events only, saturating at 1023.
  - GAP: count GAP_CYCLES cycles.
    - Pixel event → SCAN, resume at pix+1.
    - Marker → STEP update, then LOAD.
- Step update after marker:
  - If STEP==T-1: STEP←0 and SAMPLE_DONE=1 for exactly one cycle.
  - Otherwise STEP←STEP+1.
- ADDR holds its last value in all states other than SETUP.
- SCHED_FULL is checked only in SETUP. SCHED_FULL rising during REQ_HI has no effect on the handshake in flight.
- Empty frame: no pixel events; the marker is still sent.
- Full frame: WIDTH events, then the marker.
- ACK high on entry to SETUP (stale): wait; never raise REQ.
- Worst case per frame: WIDTH scan cycles plus per-event handshake cost.
- Reset asserted mid-handshake: REQ drops asynchronously, the partial frame is lost, STEP returns to 0.

Decomposition:
- Shared package aer_pkg:
  - AER_ADDR_W=12.
  - MARKER_ADDR constant.
  - Address field layout: bit11 reserved, bit10 marker flag, bits[9:0] neuron.
  - sender state enum typedef.
- One sub-module aer_4ph_master:
  - Contains the SETUP/REQ_HI/ACK_LO/GAP handshake FSM.
  - Interface: start/addr in, done pulse out.
  - Reusable for the AEROUT side in other benches or blocks.
- The top level holds the frame register, byte loader, scanner and step counter.

Test Plan:
- WIDTH=784, T=2, frame with pixels 0, 5, 783 set → events 0x000, 0x005, 0x30F, then 0x4FF; SPK_CNT=3; STEP 0→1; no SAMPLE_DONE.
- All-zero frame → single event 0x4FF, SPK_CNT=0, LOAD_READY reasserts after GAP_CYCLES+1 cycles.
- Responder delays ACK by 25 cycles after REQ and drops it 40 cycles after REQ falls → REQ held high throughout; ADDR unchanged from SETUP until the next SETUP; no duplicate event.
- SCHED_FULL held high 30 cycles while pixel 10 is pending → REQ stays 0; 0x00A is issued on the first cycle after SCHED_FULL falls.
- Two consecutive frames with T=2 → SAMPLE_DONE pulses exactly once, one cycle after the second marker handshake completes; STEP returns to 0.
- RST_N pulled low while REQ=1 mid-frame → REQ=0 without a clock edge; after release, LOAD_READY=1 next edge, STEP=0, and the next frame starts from pixel 0.
